// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states, opcodes and the
// select/control codes driven into the datapath.
package riscv_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StExecI,
    StAluWb,
    StJal,
    StBeq,
    StTrap
  } state_e;

  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10
  } alu_op_e;

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpRtype = 7'b0110011;
  localparam logic [6:0] OpItype = 7'b0010011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpBeq   = 7'b1100011;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b101;

  localparam logic [1:0] ImmI = 2'b00;
  localparam logic [1:0] ImmS = 2'b01;
  localparam logic [1:0] ImmB = 2'b10;
  localparam logic [1:0] ImmJ = 2'b11;

  localparam logic [1:0] ResAluOut = 2'b00;
  localparam logic [1:0] ResData   = 2'b01;
  localparam logic [1:0] ResAlu    = 2'b10;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARd1   = 2'b10;

  localparam logic [1:0] SrcBRd2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    logic [1:0] imm;
    imm = ImmI;
    case (op)
      OpStore: imm = ImmS;
      OpBeq:   imm = ImmB;
      OpJal:   imm = ImmJ;
      default: imm = ImmI;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU control decode from the FSM's ALUOp and the instruction funct fields; flags funct3
// values this core does not implement.
module alu_decoder
  import riscv_pkg::*;
(
  input  alu_op_e     alu_op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        op5,
  output logic [2:0]  alu_control,
  output logic        illegal
);

  always_comb begin
    alu_control = AluAdd;
    illegal     = 1'b0;
    case (alu_op)
      AluOpAdd: alu_control = AluAdd;
      AluOpSub: alu_control = AluSub;
      default: begin
        case (funct3)
          // Only R-type (op5=1) uses funct7b5 to select sub; addi ignores it.
          3'b000:  alu_control = (funct7b5 & op5) ? AluSub : AluAdd;
          3'b010:  alu_control = AluSlt;
          3'b110:  alu_control = AluOr;
          3'b111:  alu_control = AluAnd;
          default: illegal     = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I control FSM with memory-ready handshake, sticky illegal trap and a
// retired-instruction counter.
module mc_control_unit
  import riscv_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [6:0]       i_op,
  input  logic [2:0]       i_funct3,
  input  logic             i_funct7b5,
  input  logic             i_zero,
  input  logic             i_mem_ready,
  output logic             o_pc_write,
  output logic             o_adr_src,
  output logic             o_ir_write,
  output logic             o_mem_write,
  output logic             o_reg_write,
  output logic [1:0]       o_result_src,
  output logic [1:0]       o_alu_src_a,
  output logic [1:0]       o_alu_src_b,
  output logic [2:0]       o_alu_control,
  output logic [1:0]       o_imm_src,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_instret
);

  state_e           state_q, state_d;
  logic             illegal_q;
  logic [CNT_W-1:0] instret_q;
  alu_op_e          alu_op;
  logic             alu_illegal;
  logic             retire;

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (i_funct3),
    .funct7b5    (i_funct7b5),
    .op5         (i_op[5]),
    .alu_control (o_alu_control),
    .illegal     (alu_illegal)
  );

  always_comb begin
    state_d      = state_q;
    o_pc_write   = 1'b0;
    o_adr_src    = 1'b0;
    o_ir_write   = 1'b0;
    o_mem_write  = 1'b0;
    o_reg_write  = 1'b0;
    o_result_src = ResAluOut;
    o_alu_src_a  = SrcAPc;
    o_alu_src_b  = SrcBRd2;
    alu_op       = AluOpAdd;
    unique case (state_q)
      StFetch: begin
        o_alu_src_b  = SrcBFour;
        o_result_src = ResAlu;
        if (i_mem_ready) begin
          o_pc_write = 1'b1;
          o_ir_write = 1'b1;
          state_d    = StDecode;
        end
      end
      StDecode: begin
        o_alu_src_a = SrcAOldPc;
        o_alu_src_b = SrcBImm;
        case (i_op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRtype:         state_d = StExecR;
          OpItype:         state_d = StExecI;
          OpJal:           state_d = StJal;
          OpBeq:           state_d = StBeq;
          default:         state_d = StTrap;
        endcase
      end
      StMemAdr: begin
        o_alu_src_a = SrcARd1;
        o_alu_src_b = SrcBImm;
        state_d     = (i_op == OpLoad) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        o_adr_src = 1'b1;
        if (i_mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        o_result_src = ResData;
        o_reg_write  = 1'b1;
        state_d      = StFetch;
      end
      StMemWrite: begin
        o_adr_src   = 1'b1;
        o_mem_write = 1'b1;
        if (i_mem_ready) state_d = StFetch;
      end
      StExecR: begin
        o_alu_src_a = SrcARd1;
        o_alu_src_b = SrcBRd2;
        alu_op      = AluOpFunct;
        state_d     = alu_illegal ? StTrap : StAluWb;
      end
      StExecI: begin
        o_alu_src_a = SrcARd1;
        o_alu_src_b = SrcBImm;
        alu_op      = AluOpFunct;
        state_d     = alu_illegal ? StTrap : StAluWb;
      end
      StAluWb: begin
        o_reg_write = 1'b1;
        state_d     = StFetch;
      end
      StJal: begin
        o_alu_src_a = SrcAOldPc;
        o_alu_src_b = SrcBFour;
        o_pc_write  = 1'b1;
        state_d     = StAluWb;
      end
      StBeq: begin
        o_alu_src_a = SrcARd1;
        o_alu_src_b = SrcBRd2;
        alu_op      = AluOpSub;
        o_pc_write  = i_zero;
        state_d     = StFetch;
      end
      StTrap:  state_d = StTrap;
      default: state_d = StFetch;
    endcase

    // Reset overrides the state decode so no architectural write can slip through.
    if (i_rst) begin
      o_pc_write  = 1'b0;
      o_ir_write  = 1'b0;
      o_mem_write = 1'b0;
      o_reg_write = 1'b0;
    end
  end

  assign retire = (state_d == StFetch) &&
                  (state_q inside {StMemWb, StMemWrite, StAluWb, StBeq});

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == StTrap) illegal_q <= 1'b1;
      if (retire)            instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign o_imm_src = imm_src_of(i_op);
  assign o_illegal = illegal_q;
  assign o_instret = instret_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: per-cycle expected output vectors go through a
// scoreboard queue and are compared shortly after each falling edge.
module tb_mc_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic        f7b5, zero, ready;
  logic        pc_write, adr_src, ir_write, mem_write, reg_write, illegal;
  logic [1:0]  result_src, src_a, src_b, imm_src;
  logic [2:0]  alu_control;
  logic [31:0] instret;

  mc_control_unit #(.CNT_W(32)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_op          (op),
    .i_funct3      (f3),
    .i_funct7b5    (f7b5),
    .i_zero        (zero),
    .i_mem_ready   (ready),
    .o_pc_write    (pc_write),
    .o_adr_src     (adr_src),
    .o_ir_write    (ir_write),
    .o_mem_write   (mem_write),
    .o_reg_write   (reg_write),
    .o_result_src  (result_src),
    .o_alu_src_a   (src_a),
    .o_alu_src_b   (src_b),
    .o_alu_control (alu_control),
    .o_imm_src     (imm_src),
    .o_illegal     (illegal),
    .o_instret     (instret)
  );

  always #5 clk = ~clk;

  // {pcw, adr, irw, memw, regw, result[2], src_a[2], src_b[2], alu[3], imm[2], illegal, instret[32]}
  logic [48:0] obs;
  assign obs = {pc_write, adr_src, ir_write, mem_write, reg_write, result_src, src_a, src_b,
                alu_control, imm_src, illegal, instret};

  typedef struct packed {
    logic [48:0] exp;
    logic [48:0] mask;
  } sb_t;

  sb_t         sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_ret = '0;

  localparam logic [48:0] FULL    = '1;
  localparam logic [48:0] NO_ALU  = ~(49'h7 << 35);
  localparam logic [48:0] EN_MASK = {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 11'b0, 1'b1, 32'hffff_ffff};

  function automatic logic [48:0] ev(input logic pcw, adr, irw, mw, rw, input logic [1:0] rs,
                                     input logic [1:0] sa, sb, input logic [2:0] alu,
                                     input logic [1:0] imm, input logic ill,
                                     input logic [31:0] ret);
    return {pcw, adr, irw, mw, rw, rs, sa, sb, alu, imm, ill, ret};
  endfunction

  function automatic logic [48:0] fetch_e(input logic rdy, input logic [1:0] imm,
                                          input logic [31:0] ret);
    return ev(rdy, 1'b0, rdy, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, imm, 1'b0, ret);
  endfunction

  function automatic logic [48:0] decode_e(input logic [1:0] imm, input logic [31:0] ret);
    return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 1'b0, ret);
  endfunction

  function automatic logic [48:0] aluwb_e(input logic [1:0] imm, input logic [31:0] ret);
    return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1'b0, ret);
  endfunction

  function automatic logic [48:0] trap_e(input logic [31:0] ret);
    return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1, ret);
  endfunction

  // Drive one cycle of stimulus on the falling edge, record its expectation, settle outputs.
  task automatic step(input logic [6:0] o, input logic [2:0] f, input logic f7,
                      input logic z, input logic rdy, input logic r,
                      input logic [48:0] e, input logic [48:0] m);
    sb_t ent;
    @(negedge clk);
    op = o; f3 = f; f7b5 = f7; zero = z; ready = rdy; rst = r;
    ent.exp  = e;
    ent.mask = m;
    sb_q.push_back(ent);
    #1;
  endtask

  task automatic test_reset();
    sb_t got;
    rst = 1'b1; ready = 1'b1; op = 7'b0110011; f3 = '0; f7b5 = 1'b0; zero = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      step(7'b0110011, 3'b000, 1'b0, 1'b0, (i == 0), (i == 0), fetch_e(1'b0, 2'b00, 0), FULL);
      got = sb_q.pop_front();
      checks++;
      if (((obs ^ got.exp) & got.mask) !== '0) begin
        errors++;
        $display("FAIL reset[%0d] got %h required %h", i, obs, got.exp);
      end
    end
  endtask

  task automatic test_rtype();
    sb_t got;
    logic [48:0] e[5];
    logic [4:0] rdy = 5'b00001;
    e[0] = fetch_e(1'b1, 2'b00, exp_ret);
    e[1] = decode_e(2'b00, exp_ret);
    e[2] = ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00, 0, exp_ret);
    e[3] = aluwb_e(2'b00, exp_ret);
    e[4] = fetch_e(1'b0, 2'b00, exp_ret + 1);
    for (int i = 0; i < 5; i++) begin
      step(7'b0110011, 3'b000, 1'b1, 1'b0, rdy[i], 1'b0, e[i], FULL);
      got = sb_q.pop_front();
      checks++;
      if (((obs ^ got.exp) & got.mask) !== '0) begin
        errors++;
        $display("FAIL rtype_sub[%0d] got %h required %h", i, obs, got.exp);
      end
    end
    exp_ret++;
  endtask

  task automatic test_load_wait();
    sb_t got;
    logic [48:0] e[9];
    logic [8:0] rdy = 9'b001000001;
    e[0] = fetch_e(1'b1, 2'b00, exp_ret);
    e[1] = decode_e(2'b00, exp_ret);
    e[2] = ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0, exp_ret);
    for (int k = 3; k < 7; k++) e[k] = ev(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, exp_ret);
    e[7] = ev(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 0, exp_ret);
    e[8] = fetch_e(1'b0, 2'b00, exp_ret + 1);
    for (int i = 0; i < 9; i++) begin
      step(7'b0000011, 3'b010, 1'b0, 1'b0, rdy[i], 1'b0, e[i], FULL);
      got = sb_q.pop_front();
      checks++;
      if (((obs ^ got.exp) & got.mask) !== '0) begin
        errors++;
        $display("FAIL load_wait[%0d] got %h required %h", i, obs, got.exp);
      end
    end
    exp_ret++;
  endtask

  task automatic test_store();
    sb_t got;
    logic [48:0] e[6];
    logic [5:0] rdy = 6'b010001;
    e[0] = fetch_e(1'b1, 2'b01, exp_ret);
    e[1] = decode_e(2'b01, exp_ret);
    e[2] = ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 0, exp_ret);
    e[3] = ev(0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, exp_ret);
    e[4] = e[3];
    e[5] = fetch_e(1'b0, 2'b01, exp_ret + 1);
    for (int i = 0; i < 6; i++) begin
      step(7'b0100011, 3'b010, 1'b0, 1'b0, rdy[i], 1'b0, e[i], FULL);
      got = sb_q.pop_front();
      checks++;
      if (((obs ^ got.exp) & got.mask) !== '0) begin
        errors++;
        $display("FAIL store[%0d] got %h required %h", i, obs, got.exp);
      end
    end
    exp_ret++;
  endtask

  task automatic test_beq();
    sb_t got;
    logic [48:0] e[4];
    for (int z = 1; z >= 0; z--) begin
      e[0] = fetch_e(1'b1, 2'b10, exp_ret);
      e[1] = decode_e(2'b10, exp_ret);
      e[2] = ev(z[0], 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 0, exp_ret);
      e[3] = fetch_e(1'b0, 2'b10, exp_ret + 1);
      for (int i = 0; i < 4; i++) begin
        step(7'b1100011, 3'b000, 1'b0, z[0], (i == 0), 1'b0, e[i], FULL);
        got = sb_q.pop_front();
        checks++;
        if (((obs ^ got.exp) & got.mask) !== '0) begin
          errors++;
          $display("FAIL beq_zero%0d[%0d] got %h required %h", z, i, obs, got.exp);
        end
      end
      exp_ret++;
    end
  endtask

  task automatic test_jal();
    sb_t got;
    logic [48:0] e[5];
    e[0] = fetch_e(1'b1, 2'b11, exp_ret);
    e[1] = decode_e(2'b11, exp_ret);
    e[2] = ev(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11, 0, exp_ret);
    e[3] = aluwb_e(2'b11, exp_ret);
    e[4] = fetch_e(1'b0, 2'b11, exp_ret + 1);
    for (int i = 0; i < 5; i++) begin
      step(7'b1101111, 3'b000, 1'b0, 1'b0, (i == 0), 1'b0, e[i], FULL);
      got = sb_q.pop_front();
      checks++;
      if (((obs ^ got.exp) & got.mask) !== '0) begin
        errors++;
        $display("FAIL jal[%0d] got %h required %h", i, obs, got.exp);
      end
    end
    exp_ret++;
  endtask

  task automatic test_execi();
    sb_t got;
    logic [48:0] e[5];
    logic [2:0] fn[4]  = '{3'b000, 3'b010, 3'b110, 3'b111};
    logic [2:0] alu[4] = '{3'b000, 3'b101, 3'b011, 3'b010};
    for (int k = 0; k < 4; k++) begin
      e[0] = fetch_e(1'b1, 2'b00, exp_ret);
      e[1] = decode_e(2'b00, exp_ret);
      e[2] = ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu[k], 2'b00, 0, exp_ret);
      e[3] = aluwb_e(2'b00, exp_ret);
      e[4] = fetch_e(1'b0, 2'b00, exp_ret + 1);
      for (int i = 0; i < 5; i++) begin
        step(7'b0010011, fn[k], 1'b1, 1'b0, (i == 0), 1'b0, e[i], FULL);
        got = sb_q.pop_front();
        checks++;
        if (((obs ^ got.exp) & got.mask) !== '0) begin
          errors++;
          $display("FAIL execi_f3_%0d[%0d] got %h required %h", fn[k], i, obs, got.exp);
        end
      end
      exp_ret++;
    end
  endtask

  task automatic test_mid_reset();
    sb_t got;
    logic [48:0] e[5];
    logic [4:0] rst_v = 5'b01000;
    e[0] = fetch_e(1'b1, 2'b00, exp_ret);
    e[1] = decode_e(2'b00, exp_ret);
    e[2] = ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00, 0, exp_ret);
    e[3] = ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, exp_ret);
    e[4] = fetch_e(1'b0, 2'b00, 0);
    for (int i = 0; i < 5; i++) begin
      step(7'b0110011, 3'b000, 1'b1, 1'b0, (i == 0), rst_v[i], e[i], FULL);
      got = sb_q.pop_front();
      checks++;
      if (((obs ^ got.exp) & got.mask) !== '0) begin
        errors++;
        $display("FAIL mid_reset[%0d] got %h required %h", i, obs, got.exp);
      end
    end
    exp_ret = '0;
  endtask

  // Shared by the bad-funct3 and bad-opcode cases: reach TRAP, check stickiness, clear by reset.
  task automatic test_trap(input string name, input logic [6:0] o, input logic [2:0] f);
    sb_t got;
    logic [48:0] e[7];
    logic [48:0] m[7];
    logic [6:0] rst_v = 7'b0100000;
    logic [6:0] rdy   = 7'b0011101;
    e[0] = fetch_e(1'b1, 2'b00, exp_ret);                       m[0] = FULL;
    e[1] = decode_e(2'b00, exp_ret);                            m[1] = FULL;
    e[2] = ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 2'b00, 0, exp_ret);
    m[2] = NO_ALU;
    if (o != 7'b0110011) begin
      e[2] = trap_e(exp_ret);
      m[2] = EN_MASK;
    end
    e[3] = trap_e(exp_ret);                                     m[3] = EN_MASK;
    e[4] = trap_e(exp_ret);                                     m[4] = EN_MASK;
    e[5] = trap_e(exp_ret);                                     m[5] = EN_MASK;
    e[6] = fetch_e(1'b0, 2'b00, 0);                             m[6] = FULL;
    for (int i = 0; i < 7; i++) begin
      step(o, f, 1'b0, 1'b1, rdy[i], rst_v[i], e[i], m[i]);
      got = sb_q.pop_front();
      checks++;
      if (((obs ^ got.exp) & got.mask) !== '0) begin
        errors++;
        $display("FAIL %s[%0d] got %h required %h", name, i, obs, got.exp);
      end
    end
    exp_ret = '0;
  endtask

  initial begin
    rst = 1'b1; op = '0; f3 = '0; f7b5 = 1'b0; zero = 1'b0; ready = 1'b0;
    test_reset();
    test_rtype();
    test_load_wait();
    test_store();
    test_beq();
    test_jal();
    test_execi();
    test_mid_reset();
    test_trap("bad_funct3", 7'b0110011, 3'b001);
    test_trap("bad_opcode", 7'b1111111, 3'b000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
